rssb_ctrl: RTL

Sequencer for the RSSB (Reverse Subtract and Skip if Borrow) one-instruction core. It owns the program counter and accumulator and drives the 8-bit memory port of the RAM: fetch the operand address, read the operand, compute `mem[x] − A`, write the result back, and advance or skip. It sits between the top-level run/stop controls and the RAM. It is the only master of the RAM write enable.

---
 rtl/rssb_pkg.sv | 15 +
 rtl/rssb_sub.sv | 17 +
 rtl/rssb_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rssb_pkg.sv
// Shared types and default constants for the RSSB one-instruction core.
package rssb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WB,
    HALT
  } rssb_state_t;

  localparam logic [7:0] RSSB_RESET_PC  = 8'h80;
  localparam logic [7:0] RSSB_HALT_ADDR = 8'hFF;

endpackage

// File: rtl/rssb_sub.sv
// Reverse subtract m - a, widened by one bit so the top bit is the borrow.
module rssb_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] full;

  assign full   = {1'b0, m} - {1'b0, a};
  assign diff   = full[WIDTH-1:0];
  assign borrow = full[WIDTH];

endmodule

// File: rtl/rssb_ctrl.sv
// RSSB sequencer: owns PC, accumulator and the RAM port; one instruction
// takes FETCH, EXEC and WB, with a borrow skipping the next word.
module rssb_ctrl
  import rssb_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = RSSB_RESET_PC,
  parameter logic [WIDTH-1:0] HALT_ADDR = RSSB_HALT_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             halted,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] acc,
  output logic [15:0]      instr_cnt
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(1);
  localparam logic [WIDTH-1:0] PC_SKIP = WIDTH'(2);

  rssb_state_t      state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;

  rssb_sub #(.WIDTH(WIDTH)) u_sub (
    .m      (mem_rdata),
    .a      (acc_q),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the combinational block below uses blocking ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      acc_q    <= '0;
      x_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every output and next-state value gets a default first so no latch
  // is inferred; memory-port outputs decode from state, so an asynchronous
  // reset drops mem_write in the same instant.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    x_d       = x_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_wdata = '0;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        mem_addr = pc_q;
        x_d      = mem_rdata;
        if (mem_rdata == HALT_ADDR || stop) state_d = HALT;
        else                                state_d = EXEC;
      end
      EXEC: begin
        mem_addr = x_q;
        diff_d   = sub_diff;
        borrow_d = sub_borrow;
        state_d  = WB;
      end
      WB: begin
        mem_addr  = x_q;
        mem_write = 1'b1;
        mem_wdata = diff_q;
        acc_d     = diff_q;
        pc_d      = pc_q + (borrow_q ? PC_SKIP : PC_STEP);
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        state_d   = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == FETCH) || (state_q == EXEC) || (state_q == WB);
  assign halted    = (state_q == HALT);
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign instr_cnt = cnt_q;

endmodule
